// File: rtl/mtm_alu_deserializer_if.sv
// Serial-in / operand-out bundle between the serial line driver and the ALU deserializer.
//   sin        serial data, idles high, one bit per clk
//   A, B       32-bit operands, held until the next out_valid
//   CTL        8-bit control byte (or error code) for the ALU core
//   out_valid  single-cycle pulse marking a new A/B/CTL set
// master: drives sin, observes the operand outputs. slave: the deserializer.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] A;
  logic [31:0] B;
  logic [7:0]  CTL;
  logic        out_valid;

  modport master (
    output sin,
    input  A,
    input  B,
    input  CTL,
    input  out_valid
  );

  modport slave (
    input  sin,
    output A,
    output B,
    output CTL,
    output out_valid
  );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// Serial packet deserializer for the MTM ALU.
// Receives 11-bit frames {start(0), type, D[7:0] MSB first, stop(1)} on bus.sin. Data frames
// (type 0) build B (bytes 0-3) then A (bytes 4-7); a control frame (type 1) carrying
// {1'b0, OP[2:0], CRC[3:0]} closes the packet and produces one out_valid pulse with A/B/CTL,
// or an error code in CTL (A = B = 0) when the packet is malformed.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  slave side of mtm_alu_deserializer_if (sin in; A, B, CTL, out_valid out)
module mtm_alu_deserializer (
  input logic                   clk,
  input logic                   rst,
  mtm_alu_deserializer_if.slave bus
);

  localparam logic [7:0] CtlErrData = 8'hC9;
  localparam logic [7:0] CtlErrCrc  = 8'hA5;
  localparam logic [7:0] CtlErrOp   = 8'h93;

  typedef enum logic [1:0] {StIdle, StType, StData, StStop} state_e;

  state_e      state_q;
  logic        type_q;      // 0 = data frame, 1 = control frame
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [63:0] pkt_q;       // {B, A} once 8 bytes are in
  logic [3:0]  byte_cnt_q;
  logic        overrun_q;
  logic [3:0]  crc_q;

  // CRC input selection. Data frames feed every bit. In a control frame the first data bit
  // (always 0 on the wire) stands in for the 1'b1 marker, the next three are OP, and the
  // CRC field itself is not fed, so crc_q ends up covering {B, A, 1'b1, OP}.
  logic       crc_en;
  logic       crc_bit;
  logic       crc_fb;
  logic [3:0] crc_next;

  always_comb begin
    crc_en  = 1'b0;
    crc_bit = bus.sin;
    if (!type_q) begin
      crc_en = 1'b1;
    end else if (bit_cnt_q == 3'd0) begin
      crc_en  = 1'b1;
      crc_bit = 1'b1;
    end else if (bit_cnt_q <= 3'd3) begin
      crc_en = 1'b1;
    end
  end

  // Serial x^4 + x + 1, MSB first.
  assign crc_fb   = crc_q[3] ^ crc_bit;
  assign crc_next = {crc_q[2:0], 1'b0} ^ {2'b00, crc_fb, crc_fb};

  logic [2:0] op;
  logic       op_ok;
  logic       err_data;
  logic       err_crc;

  assign op       = shift_q[6:4];
  assign err_data = (byte_cnt_q != 4'd8) || overrun_q;
  assign err_crc  = (crc_q != shift_q[3:0]);

  always_comb begin
    case (op)
      3'b000, 3'b001, 3'b100, 3'b101: op_ok = 1'b1;
      default:                        op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      type_q        <= 1'b0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      pkt_q         <= 64'h0;
      byte_cnt_q    <= 4'd0;
      overrun_q     <= 1'b0;
      crc_q         <= 4'h0;
      bus.A         <= 32'h0;
      bus.B         <= 32'h0;
      bus.CTL       <= 8'h00;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!bus.sin) begin
            state_q <= StType;
          end
        end
        StType: begin
          type_q    <= bus.sin;
          bit_cnt_q <= 3'd0;
          state_q   <= StData;
        end
        StData: begin
          shift_q   <= {shift_q[6:0], bus.sin};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (crc_en) begin
            crc_q <= crc_next;
          end
          if (bit_cnt_q == 3'd7) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          state_q <= StIdle;
          if (!bus.sin) begin
            // Framing error: drop the whole packet silently.
            pkt_q      <= 64'h0;
            byte_cnt_q <= 4'd0;
            overrun_q  <= 1'b0;
            crc_q      <= 4'h0;
          end else if (!type_q) begin
            if (byte_cnt_q == 4'd8) begin
              overrun_q <= 1'b1;
            end else begin
              pkt_q      <= {pkt_q[55:0], shift_q};
              byte_cnt_q <= byte_cnt_q + 4'd1;
            end
          end else begin
            bus.out_valid <= 1'b1;
            if (err_data) begin
              bus.A   <= 32'h0;
              bus.B   <= 32'h0;
              bus.CTL <= CtlErrData;
            end else if (err_crc) begin
              bus.A   <= 32'h0;
              bus.B   <= 32'h0;
              bus.CTL <= CtlErrCrc;
            end else if (!op_ok) begin
              bus.A   <= 32'h0;
              bus.B   <= 32'h0;
              bus.CTL <= CtlErrOp;
            end else begin
              bus.A   <= pkt_q[31:0];
              bus.B   <= pkt_q[63:32];
              bus.CTL <= shift_q;
            end
            pkt_q      <= 64'h0;
            byte_cnt_q <= 4'd0;
            overrun_q  <= 1'b0;
            crc_q      <= 4'h0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
module tb_mtm_alu_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mtm_alu_deserializer_if bus ();

  mtm_alu_deserializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stop_cyc = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  ctl;
    int          cyc;
  } obs_t;

  obs_t obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      obs_q.push_back('{a: bus.A, b: bus.B, ctl: bus.CTL, cyc: cyc});
    end
  end

  // ---------------- reference model ----------------
  // CRC as the remainder of ({B, A, 1, OP} * x^4) mod (x^4 + x + 1), by long division.
  function automatic logic [3:0] crc_of(input logic [31:0] b, input logic [31:0] a,
                                        input logic [2:0] op);
    logic [71:0] v;
    v = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (v[i]) v[i-:5] = v[i-:5] ^ 5'b10011;
    end
    return v[3:0];
  endfunction

  function automatic void model(input int n, input logic [7:0] d[16], input logic [7:0] ctl,
                                output logic [31:0] ea, output logic [31:0] eb,
                                output logic [7:0] ec);
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    ea = 32'h0;
    eb = 32'h0;
    if (n != 8) begin
      ec = 8'hC9;
      return;
    end
    b  = {d[0], d[1], d[2], d[3]};
    a  = {d[4], d[5], d[6], d[7]};
    op = ctl[6:4];
    if (crc_of(b, a, op) != ctl[3:0]) ec = 8'hA5;
    else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) ec = 8'h93;
    else begin
      ea = a;
      eb = b;
      ec = ctl;
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_bit(input logic v);
    @(negedge clk);
    bus.sin = v;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop,
                            input int gap);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    stop_cyc = cyc + 1;
    repeat (gap) send_bit(1'b1);
  endtask

  task automatic send_packet(input int n, input logic [7:0] d[16], input logic [7:0] ctl,
                             input int max_gap);
    for (int i = 0; i < n; i++) send_frame(1'b0, d[i], 1'b1, $urandom_range(0, max_gap));
    send_frame(1'b1, ctl, 1'b1, 0);
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sin = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.sin = 1'b1;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.A, bus.B, bus.CTL, bus.out_valid} !== 73'h0) begin
      n_fail++;
      $display("FAIL reset_values: got A=%h B=%h CTL=%h ov=%b, expected all zero",
               bus.A, bus.B, bus.CTL, bus.out_valid);
    end
    rst = 1'b0;
    settle(3);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  // Send one packet and check exactly one matching pulse with 1-cycle latency.
  task automatic test_packet(input string name, input int n, input logic [7:0] d[16],
                             input logic [7:0] ctl, input int max_gap);
    logic [31:0] ea;
    logic [31:0] eb;
    logic [7:0]  ec;
    obs_q.delete();
    model(n, d, ctl, ea, eb, ec);
    send_packet(n, d, ctl, max_gap);
    settle(4);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL %s count: got %0d pulses expected 1", name, obs_q.size());
    end else begin
      n_checks++;
      if ({obs_q[0].a, obs_q[0].b, obs_q[0].ctl} !== {ea, eb, ec}) begin
        n_fail++;
        $display("FAIL %s value: got A=%h B=%h CTL=%h expected A=%h B=%h CTL=%h",
                 name, obs_q[0].a, obs_q[0].b, obs_q[0].ctl, ea, eb, ec);
      end
      n_checks++;
      if (obs_q[0].cyc !== stop_cyc) begin
        n_fail++;
        $display("FAIL %s latency: got cycle %0d expected %0d", name, obs_q[0].cyc, stop_cyc);
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0] d[16];
    logic [2:0] op;
    foreach (d[i]) d[i] = 8'h00;
    test_packet("zero_pkt", 8, d, 8'h0B, 2);
    d[3] = 8'h01;
    for (int i = 4; i < 8; i++) d[i] = 8'hFF;
    op = 3'b100;
    test_packet("add_pkt", 8, d, {1'b0, op, crc_of(32'h1, 32'hFFFF_FFFF, op)}, 1);
    foreach (d[i]) d[i] = 8'h00;
    test_packet("bad_crc", 8, d, 8'h0A, 0);
    test_packet("bad_op", 8, d, 8'h2D, 0);
  endtask

  task automatic test_byte_count();
    logic [7:0] d[16];
    foreach (d[i]) d[i] = 8'h00;
    test_packet("short_pkt", 7, d, 8'h0B, 1);
    test_packet("overrun_pkt", 9, d, 8'h0B, 1);
  endtask

  task automatic random_valid(output logic [7:0] d[16], output logic [7:0] ctl);
    logic [2:0] op;
    foreach (d[i]) d[i] = 8'($urandom);
    case ($urandom_range(0, 3))
      0: op = 3'b000;
      1: op = 3'b001;
      2: op = 3'b100;
      default: op = 3'b101;
    endcase
    ctl = {1'b0, op, crc_of({d[0], d[1], d[2], d[3]}, {d[4], d[5], d[6], d[7]}, op)};
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] d[16];
    logic [7:0] ctl;
    random_valid(d, ctl);
    obs_q.delete();
    for (int i = 0; i < 5; i++) send_frame(1'b0, d[i], 1'b1, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    settle(2);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_pkt early: got %0d pulses expected 0", obs_q.size());
    end
    random_valid(d, ctl);
    test_packet("after_reset", 8, d, ctl, 1);
  endtask

  task automatic test_bad_stop();
    logic [7:0] d[16];
    logic [7:0] ctl;
    random_valid(d, ctl);
    obs_q.delete();
    for (int i = 0; i < 4; i++) send_frame(1'b0, d[i], (i == 3) ? 1'b0 : 1'b1, 2);
    settle(6);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL bad_stop: got %0d pulses expected 0", obs_q.size());
    end
    random_valid(d, ctl);
    test_packet("after_bad_stop", 8, d, ctl, 2);
  endtask

  task automatic test_random();
    logic [7:0] d[16];
    logic [7:0] ctl;
    int         n;
    for (int k = 0; k < 30; k++) begin
      random_valid(d, ctl);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : 8;
      if ($urandom_range(0, 4) == 0) ctl[3:0] = ctl[3:0] ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) ctl[6:4] = 3'($urandom);
      test_packet("random", n, d, ctl, 3);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[16];
    logic [7:0] ctl;
    for (int k = 0; k < 4; k++) begin
      random_valid(d, ctl);
      test_packet("back_to_back", 8, d, ctl, 0);
    end
  endtask

  initial begin
    bus.sin = 1'b1;
    test_reset();
    test_directed();
    test_byte_count();
    test_reset_mid_packet();
    test_bad_stop();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtm_alu_deserializer.md
MTM_ALU_DESERIALIZER -- requirements
Module: mtm_Alu_deserializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: sin  input  1  serial data in; idles high; one bit per clk cycle.
REQ-005 Port: A  output  32  operand A, registered, held until the next out_valid.
REQ-006 Port: B  output  32  operand B, registered, held until the next out_valid.
REQ-007 Port: CTL  output  8  control byte to the ALU core, registered, held until the next out_valid.
REQ-008 Port: out_valid  output  1  single-cycle pulse marking a new A/B/CTL set.

Function
REQ-009 Frame format SHALL be 11 bits, first in time first: start(0), type, D[7:0] MSB first, stop(1); type 0 = data frame, type 1 = control frame.
REQ-010 Frame FSM SHALL use states IDLE, TYPE, DATA, STOP.
REQ-011 IDLE -> TYPE SHALL occur on sin==0 sampled in IDLE.
REQ-012 TYPE -> DATA SHALL occur after one cycle, latching the type bit.
REQ-013 DATA SHALL last exactly 8 cycles, shifting sin in via a 3-bit counter, then go to STOP.
REQ-014 STOP -> IDLE SHALL occur after one cycle; a new start bit is accepted in the cycle immediately after STOP.
REQ-015 A stop bit sampled as 0 SHALL discard the frame and the whole packet in progress (byte count cleared, no output), with return to IDLE.
REQ-016 Packet assembly SHALL accept data frames as bytes 0-3 -> B[31:24..7:0] and bytes 4-7 -> A[31:24..7:0], MSB byte first.
REQ-017 A data frame arriving when 8 bytes are already held SHALL set a sticky overrun flag; the operand registers SHALL be left unchanged.
REQ-018 The control frame byte SHALL be {1'b0, OP[2:0], CRC[3:0]}; a control frame SHALL always terminate the packet.
REQ-019 The 4-bit CRC SHALL use polynomial x^4+x+1, init 0, computed serially MSB-first over 68 bits {B, A, 1'b1, OP}.
REQ-020 Valid OP values SHALL be 000 (AND), 001 (OR), 100 (ADD), 101 (SUB).
REQ-021 Error check priority SHALL be ERR_DATA > ERR_CRC > ERR_OP, evaluated at control-frame stop.
REQ-022 ERR_DATA (byte count != 8 or overrun set) SHALL output CTL = 8'hC9.
REQ-023 ERR_CRC SHALL output CTL = 8'hA5.
REQ-024 ERR_OP SHALL output CTL = 8'h93.
REQ-025 With no error, CTL SHALL equal the received control byte.
REQ-026 On error, A and B SHALL be 0.
REQ-027 out_valid SHALL assert for exactly one cycle, in the cycle after the control frame's stop bit is sampled, with A/B/CTL valid in that same cycle.
REQ-028 Latency SHALL be 1 cycle from the control-frame stop-bit sample to out_valid.
REQ-029 After each control frame, the byte count, overrun flag and CRC state SHALL clear.
REQ-030 A bit-1 sampled in IDLE SHALL be ignored; an arbitrary idle gap is allowed between frames and between packets.

Reset
REQ-031 When rst is high at a clk edge, the FSM SHALL go to IDLE and the byte count, overrun flag and shift registers SHALL clear.
REQ-032 Reset values SHALL be A=0, B=0, CTL=8'h00, out_valid=0.
REQ-033 Reset mid-frame or mid-packet SHALL discard all partial data with no out_valid afterwards until a complete new packet is received.

Verification
REQ-034 Scenario: 8 data frames 8'h00, then control 8'h0B -> one out_valid pulse with A=0, B=0, CTL=8'h0B.
REQ-035 Scenario: B=32'h00000001, A=32'hFFFFFFFF, OP=100, CRC from the model -> A/B reproduced exactly and CTL equal to the sent byte, 1 cycle after the stop bit.
REQ-036 Scenario: 8 zero data frames, then control 8'h0A (bad CRC) -> CTL=8'hA5, A=B=0.
REQ-037 Scenario: 7 zero data frames, then control 8'h0B -> CTL=8'hC9; with 9 data frames -> CTL=8'hC9.
REQ-038 Scenario: 8 zero data frames, then control 8'h2D (OP=010, CRC correct) -> CTL=8'h93.
REQ-039 Scenario: rst pulsed after 5 data frames, then a full valid packet -> exactly one out_valid, for the new packet only.
REQ-040 Scenario: stop bit forced to 0 in data byte 3 -> no out_valid; a following full packet decodes correctly.
